// File: rtl/seg_scan_display_if.sv
// Bundle of signals between the counter stage and the seven-segment
// scanner: the count and direction in, the display drive and busy flag out.
interface seg_scan_display_if;
  logic [7:0] value;
  logic       dir;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  modport master (output value, dir, input seg, dp, an, busy);
  modport slave  (input value, dir, output seg, dp, an, busy);
endinterface

// File: rtl/seg_scan_display.sv
// Converts the 8-bit count to three BCD digits with a serial double-dabble
// engine and multiplexes them, plus a direction glyph, onto a 4-digit
// seven-segment display.
module seg_scan_display #(
  parameter int SCAN_DIV         = 50000,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int DIGIT_ACTIVE_LOW = 1,
  parameter int BLANK_LEADING    = 1
) (
  input logic              clk,
  input logic              clr_n,
  seg_scan_display_if.slave bus
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam bit SEG_INV   = (SEG_ACTIVE_LOW != 0);
  localparam bit AN_INV    = (DIGIT_ACTIVE_LOW != 0);
  localparam bit BLANK_EN  = (BLANK_LEADING != 0);
  localparam logic [6:0] SEG_OFF = SEG_INV ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = AN_INV ? 4'b1111 : 4'b0000;
  localparam logic       DP_OFF  = SEG_INV ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t        state;
  logic [7:0]    last_value;
  logic [7:0]    shift_reg;
  logic [11:0]   bcd;
  logic [11:0]   bcd_adj;
  logic [2:0]    bit_cnt;
  logic [3:0]    hund;
  logic [3:0]    tens;
  logic [3:0]    ones;
  logic          busy_r;

  logic [PW-1:0] prescaler;
  logic [1:0]    digit_idx;
  logic [6:0]    digit_code;
  logic [3:0]    digit_en;
  logic [6:0]    seg_r;
  logic [3:0]    an_r;
  logic          dp_r;

  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Add-3 correction on every BCD nibble ahead of this cycle's shift
  always_comb begin
    bcd_adj = {dabble(bcd[11:8]), dabble(bcd[7:4]), dabble(bcd[3:0])};
  end

  // Converter FSM: capture a new count, shift it through 8 times, then
  // publish all three digits at once so the display never sees partial sums
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      last_value <= 8'd0;
      shift_reg  <= 8'd0;
      bcd        <= 12'd0;
      bit_cnt    <= 3'd0;
      hund       <= 4'd0;
      tens       <= 4'd0;
      ones       <= 4'd0;
      busy_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.value != last_value) begin
            shift_reg  <= bus.value;
            last_value <= bus.value;
            bcd        <= 12'd0;
            bit_cnt    <= 3'd0;
            busy_r     <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, shift_reg} <= {bcd_adj[10:0], shift_reg, 1'b0};
          bit_cnt          <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= LOAD;
        end
        LOAD: begin
          hund   <= bcd[11:8];
          tens   <= bcd[7:4];
          ones   <= bcd[3:0];
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pick the glyph and enable for the digit currently being scanned,
  // applying leading-zero blanking and the live direction flag
  always_comb begin
    digit_code = 7'h00;
    digit_en   = 4'b0000;
    case (digit_idx)
      2'd0: begin
        digit_en   = 4'b0001;
        digit_code = seg_code(ones);
      end
      2'd1: begin
        digit_en = 4'b0010;
        if (!(BLANK_EN && hund == 4'd0 && tens == 4'd0)) digit_code = seg_code(tens);
      end
      2'd2: begin
        digit_en = 4'b0100;
        if (!(BLANK_EN && hund == 4'd0)) digit_code = seg_code(hund);
      end
      default: begin
        digit_en   = 4'b1000;
        digit_code = bus.dir ? 7'h5E : 7'h3E;
      end
    endcase
  end

  // Scan prescaler and digit rotation, with registered display drive
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prescaler <= '0;
      digit_idx <= 2'd0;
      seg_r     <= SEG_OFF;
      an_r      <= AN_OFF;
      dp_r      <= DP_OFF;
    end else begin
      if (prescaler == PRESC_LAST) begin
        prescaler <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      seg_r <= SEG_INV ? ~digit_code : digit_code;
      an_r  <= AN_INV ? ~digit_en : digit_en;
      dp_r  <= DP_OFF;
    end
  end

  assign bus.seg  = seg_r;
  assign bus.an   = an_r;
  assign bus.dp   = dp_r;
  assign bus.busy = busy_r;

endmodule
